simple_uart: RTL and testbench
==============================

// Module: simple_uart
// PURPOSE
//  Minimal 8N1 full-duplex UART with a one-byte receive buffer and a one-byte transmit path.
//  Serves as the serial front end for the MIDI input path: 31250 baud at 16 MHz.
//  The consumer polls recv_buf_valid and pulses reg_dat_re to pop the byte.
//  The transmitter is driven by a write strobe and reports tx_busy.
// PARAMETERS
//  CLOCK_FREQUENCY  16000000  clk frequency in Hz
//  BAUD_RATE        31250     serial bit rate in bit/s
//    DIV = CLOCK_FREQUENCY/BAUD_RATE, truncated. Default DIV = 512.
//    DIV >= 4 is required; check it at elaboration.
// PORTS
//  clk             in   1  single clock; all logic is on the rising edge
//  reset           in   1  synchronous, active-high reset
//  ser_rx          in   1  asynchronous serial input; idle level is high
//  ser_tx          out  1  serial output; idle level is high
//  reg_dat_re      in   1  read strobe; pops the receive buffer
//  reg_dat_do      out  8  received byte; reads 8'hFF when the buffer is empty
//  recv_buf_valid  out  1  receive buffer holds an unread byte
//  reg_dat_we      in   1  write strobe; starts a transmit when idle
//  reg_dat_di      in   8  byte to transmit
//  tx_busy         out  1  transmitter is active
// BEHAVIOUR
//  Reset values: ser_tx=1, recv_buf_valid=0, reg_dat_do=8'hFF, tx_busy=0.
//    Both FSMs return to IDLE; the RX synchronizer flops are set to 1.
//  Reset has priority over every other input, including mid-frame; a frame in progress is dropped.
//  ser_rx passes through a 2-FF synchronizer before any use.
//  RX FSM states: IDLE, START, DATA, STOP.
//    IDLE: a low synchronized input -> START, counter cleared.
//    START: at DIV/2 cycles, resample the line.
//      Still low -> DATA, with the counter re-timed to bit centres.
//      High -> glitch; return to IDLE.
//    DATA: sample every DIV cycles at the bit centre, 8 bits, LSB first.
//    STOP: sample the stop bit at its centre.
//      High: load the byte into the buffer, set recv_buf_valid on the next edge, go to IDLE.
//      Low (framing error): discard the byte, leave the buffer untouched,
//        wait for the line to go high, then return to IDLE.
//  Receive buffer handshake:
//    reg_dat_re=1 while valid -> recv_buf_valid=0 on the next edge.
//    reg_dat_re while empty -> no effect.
//    recv_buf_valid holds until read. A consumer that reads on valid and acks one cycle later sees each byte exactly once.
//  Overrun: a new byte overwrites the buffer and recv_buf_valid stays 1.
//  Byte completion and reg_dat_re in the same cycle: the new byte wins and valid stays 1.
//  reg_dat_do = recv_buf_valid ? buffer : 8'hFF (combinational from registers).
//  TX FSM states: IDLE, START, DATA, STOP.
//    reg_dat_we in IDLE latches reg_dat_di; tx_busy=1 from the next edge.
//    Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly DIV cycles.
//    tx_busy falls after the full stop-bit period; a new write is accepted in that same cycle.
//    reg_dat_we while busy is ignored; the write is dropped.
//  RX and TX are fully independent. Loopback of ser_tx to ser_rx must work.
//  Counters are sized to $clog2(DIV)+1 bits. Bit index is 3 bits and does not wrap past 7.
// STRUCTURE
//  Package simple_uart_pkg: RX/TX state enum (IDLE, START, DATA, STOP) and a DIV-computation function.
//  Sub-module simple_uart_rx: synchronizer plus RX FSM, outputs a byte and a done pulse.
//  The TX FSM and the receive buffer stay in the top module.
// TESTING
//  Use the default parameters, DIV=512.
//  1. Drive 0x90 on ser_rx.
//     -> recv_buf_valid rises ~9.5 bit times after the start edge, reg_dat_do=0x90.
//     -> re for 1 cycle -> valid=0 and do=0xFF on the next cycle.
//  2. Send 0x3C, then 0x7F, without reading.
//     -> after the second byte, valid=1 and do=0x7F (overrun overwrites).
//  3. Hold ser_rx low for 100 cycles (glitch), then drive 0x45 with the stop bit forced low.
//     -> valid stays 0 throughout.
//  4. we with di=0xA5.
//     -> tx_busy=1 for 10*512 cycles.
//     -> ser_tx shows 0,1,0,1,0,0,1,0,1,1 with 512 cycles per bit.
//     -> a second we while busy is dropped.
//  5. Loopback: send 0x00, 0xFF, 0x55 back to back -> each byte is received intact.
//  6. Assert reset mid-RX and mid-TX.
//     -> ser_tx=1, tx_busy=0, valid=0 on the next edge; no spurious byte after release.

Source files
------------

// File: rtl/simple_uart_pkg.sv
// simple_uart_pkg: shared FSM state type and baud divider helper for the UART
package simple_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 2-FF synchronizer and 8N1 receive FSM producing a byte with a done pulse
module simple_uart_rx import simple_uart_pkg::*; #(
    parameter int DIV = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic [7:0] data,
    output logic       done
);
    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    logic s1, s2, ferr;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            ferr <= 1'b0;
            done <= 1'b0;
            data <= '0;
        end else begin
            s1 <= ser_rx;
            s2 <= s1;
            done <= 1'b0;
            case (state)
                IDLE: if (!s2) begin
                    state <= START;
                    cnt <= '0;
                end
                START: if (cnt == HALF) begin
                    state <= s2 ? IDLE : DATA;
                    cnt <= '0;
                    idx <= '0;
                end else cnt <= cnt + CW'(1);
                DATA: if (cnt == FULL) begin
                    data <= {s2, data[7:1]};
                    cnt <= '0;
                    if (idx == 3'd7) state <= STOP;
                    else idx <= idx + 3'd1;
                end else cnt <= cnt + CW'(1);
                STOP: if (ferr) begin
                    if (s2) begin
                        ferr <= 1'b0;
                        state <= IDLE;
                    end
                end else if (cnt == FULL) begin
                    if (s2) begin
                        done <= 1'b1;
                        state <= IDLE;
                    end else ferr <= 1'b1;
                end else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/simple_uart.sv
// simple_uart: 8N1 full-duplex UART with a one-byte receive buffer and a one-byte transmit path
module simple_uart import simple_uart_pkg::*; #(
    parameter int CLOCK_FREQUENCY = 16000000,
    parameter int BAUD_RATE = 31250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       reg_dat_re,
    output logic [7:0] reg_dat_do,
    output logic       recv_buf_valid,
    input  logic       reg_dat_we,
    input  logic [7:0] reg_dat_di,
    output logic       tx_busy
);
    localparam int DIV = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    if (DIV < 4) begin : g_div_check
        $error("simple_uart: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
    end
    logic [7:0] rx_data, rx_buf, tx_sh;
    logic rx_done;
    state_t tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_idx;
    simple_uart_rx #(.DIV(DIV)) u_rx (
        .clk(clk),
        .reset(reset),
        .ser_rx(ser_rx),
        .data(rx_data),
        .done(rx_done)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            recv_buf_valid <= 1'b0;
            rx_buf <= '0;
        end else if (rx_done) begin
            recv_buf_valid <= 1'b1;
            rx_buf <= rx_data;
        end else if (reg_dat_re) recv_buf_valid <= 1'b0;
    end
    assign reg_dat_do = recv_buf_valid ? rx_buf : 8'hFF;
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_sh <= '0;
        end else begin
            case (tx_state)
                IDLE: if (reg_dat_we) begin
                    tx_state <= START;
                    tx_sh <= reg_dat_di;
                    tx_cnt <= '0;
                end
                START: if (tx_cnt == FULL) begin
                    tx_state <= DATA;
                    tx_cnt <= '0;
                    tx_idx <= '0;
                end else tx_cnt <= tx_cnt + CW'(1);
                DATA: if (tx_cnt == FULL) begin
                    tx_cnt <= '0;
                    if (tx_idx == 3'd7) tx_state <= STOP;
                    else begin
                        tx_idx <= tx_idx + 3'd1;
                        tx_sh <= tx_sh >> 1;
                    end
                end else tx_cnt <= tx_cnt + CW'(1);
                STOP: if (tx_cnt == FULL) tx_state <= IDLE;
                else tx_cnt <= tx_cnt + CW'(1);
                default: tx_state <= IDLE;
            endcase
        end
    end
    assign ser_tx = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
    assign tx_busy = tx_state != IDLE;
endmodule

// File: tb/tb_simple_uart.sv
// tb_simple_uart: randomized self-checking bench with a frame-level model of the UART
module tb_simple_uart;
    localparam int DIV = 512;
    logic clk = 1'b0, reset = 1'b1, rx_drv = 1'b1, loop = 1'b0, re = 1'b0, we = 1'b0;
    logic [7:0] di = 8'h00;
    logic ser_rx, ser_tx, valid, busy;
    logic [7:0] dout;
    int n_chk = 0, n_fail = 0;
    logic mvalid = 1'b0, settled = 1'b0;
    logic [7:0] mbuf = 8'h00;
    assign ser_rx = loop ? ser_tx : rx_drv;
    always #5 clk = ~clk;
    simple_uart dut (
        .clk(clk),
        .reset(reset),
        .ser_rx(ser_rx),
        .ser_tx(ser_tx),
        .reg_dat_re(re),
        .reg_dat_do(dout),
        .recv_buf_valid(valid),
        .reg_dat_we(we),
        .reg_dat_di(di),
        .tx_busy(busy)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    endfunction
    always @(posedge clk) begin
        #1;
        if (settled && !reset) begin
            check("rx_valid", 32'(valid), 32'(mvalid));
            check("rx_data", 32'(dout), 32'(mvalid ? mbuf : 8'hFF));
        end
    end
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic early);
        logic prev;
        prev = mvalid;
        settled = 1'b0;
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                rx_drv = k == 9 ? stop : frame_bit(b, k);
                if (early && k == 9 && c == DIV / 4) check("rx_early", 32'(valid), 32'(prev));
            end
        @(negedge clk);
        rx_drv = 1'b1;
        if (stop) begin
            mbuf = b;
            mvalid = 1'b1;
        end
        settled = 1'b1;
    endtask
    task automatic read_buf();
        @(negedge clk);
        re = 1'b1;
        settled = 1'b0;
        @(negedge clk);
        re = 1'b0;
        mvalid = 1'b0;
        settled = 1'b1;
    endtask
    task automatic tx_frame(input logic [7:0] b, input logic inject);
        we = 1'b1;
        di = b;
        @(negedge clk);
        we = 1'b0;
        for (int n = 0; n < 10 * DIV; n++) begin
            if (n % DIV == 0 || n % DIV == DIV - 1) begin
                check("tx_bit", 32'(ser_tx), 32'(frame_bit(b, n / DIV)));
                check("tx_busy", 32'(busy), 32'(1));
            end
            we = inject && n == 3 * DIV;
            if (we) di = ~b;
            @(negedge clk);
        end
        we = 1'b0;
        check("tx_end_busy", 32'(busy), 32'(0));
        check("tx_end_line", 32'(ser_tx), 32'(1));
    endtask
    initial begin
        logic [7:0] lb [3];
        logic [7:0] b, t;
        logic [9:0] a5_bits;
        lb = '{8'h00, 8'hFF, 8'h55};
        a5_bits = 10'b1101001010;
        for (int k = 0; k < 10; k++) check("model_a5", 32'(frame_bit(8'hA5, k)), 32'(a5_bits[k]));
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(ser_tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_do", 32'(dout), 32'hFF);
        reset = 1'b0;
        settled = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h90, 1'b1, 1'b1);
        check("t1_do", 32'(dout), 32'h90);
        check("t1_valid", 32'(valid), 32'(1));
        read_buf();
        check("t1_rd_valid", 32'(valid), 32'(0));
        check("t1_rd_do", 32'(dout), 32'hFF);
        repeat (4) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'h7F, 1'b1, 1'b1);
        check("t2_do", 32'(dout), 32'h7F);
        check("t2_valid", 32'(valid), 32'(1));
        read_buf();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (DIV) @(negedge clk);
        send_frame(8'h45, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_valid", 32'(valid), 32'(0));
        @(negedge clk);
        tx_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check("t4_drop", 32'(busy), 32'(0));
        settled = 1'b0;
        loop = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tx_frame(lb[i], 1'b0);
            check("lb_valid", 32'(valid), 32'(1));
            check("lb_do", 32'(dout), 32'(lb[i]));
            fork
                begin
                    re = 1'b1;
                    @(negedge clk);
                    re = 1'b0;
                end
            join_none
        end
        @(negedge clk);
        @(negedge clk);
        check("lb_rd_valid", 32'(valid), 32'(0));
        check("lb_rd_do", 32'(dout), 32'hFF);
        loop = 1'b0;
        mvalid = 1'b0;
        settled = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            t = 8'($urandom);
            fork
                send_frame(b, 1'b1, 1'b1);
                begin
                    @(negedge clk);
                    tx_frame(t, 1'($urandom % 2));
                end
            join
            if ($urandom % 2 == 1) read_buf();
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        send_frame(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        settled = 1'b0;
        rx_drv = 1'b0;
        we = 1'b1;
        di = 8'h3C;
        @(negedge clk);
        we = 1'b0;
        repeat (1500) @(negedge clk);
        reset = 1'b1;
        rx_drv = 1'b1;
        @(negedge clk);
        check("t6_tx", 32'(ser_tx), 32'(1));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_valid", 32'(valid), 32'(0));
        check("t6_do", 32'(dout), 32'hFF);
        reset = 1'b0;
        mvalid = 1'b0;
        settled = 1'b1;
        repeat (11 * DIV) @(negedge clk);
        check("t6_post_busy", 32'(busy), 32'(0));
        check("t6_post_tx", 32'(ser_tx), 32'(1));
        check("t6_post_valid", 32'(valid), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
